// File: rtl/rtc_bus_responder.sv
// Stand-in for the external RTC chip on the multiplexed cs/rd/wr/a_d/dato bus.
// BCD calendar advancing once per TICK_DIV clocks; RTC_TIMER_EN adds the countdown timer at 0x40-0x43.
module rtc_bus_responder #(
    parameter int TICK_DIV = 100_000_000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       cs,
    input  logic       rd,
    input  logic       wr,
    input  logic       a_d,
    inout  wire  [7:0] dato,
    output logic       timer_done
);
    localparam int CW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;

    logic          cs_r, rd_r, wr_r, a_d_r, rd_q, wr_q;
    logic [7:0]    dato_r;
    logic [7:0]    addr, rdata, rd_val;
    logic          oe;
    logic [CW-1:0] tick_cnt;
    logic          tick, wr_rise, bus_wr, addr_wr, rd_fall;

    logic [7:0] sec, mins, hour, day, mon, year, wday;
    logic [7:0] sec_n, mins_n, hour_n, day_n, mon_n, year_n, wday_n;
    logic [7:0] mlen;
    logic [3:0] lsum;
    logic       leap;
`ifdef RTC_TIMER_EN
    logic [7:0] t_sec, t_min, t_hour, t_sec_n, t_min_n, t_hour_n;
    logic       t_run, t_done, t_run_n, t_done_n;
`endif

    function automatic logic [7:0] bcd_inc(input logic [7:0] v);
        if (v[3:0] >= 4'd9) bcd_inc = {v[7:4] + 4'd1, 4'd0};
        else                bcd_inc = {v[7:4], v[3:0] + 4'd1};
    endfunction

    function automatic logic [7:0] bcd_dec(input logic [7:0] v, input logic [7:0] top);
        if (v == 8'h00)           bcd_dec = top;
        else if (v[3:0] == 4'd0)  bcd_dec = {v[7:4] - 4'd1, 4'd9};
        else                      bcd_dec = {v[7:4], v[3:0] - 4'd1};
    endfunction

    assign tick    = (tick_cnt == CW'(TICK_DIV - 1));
    assign wr_rise = wr_r & ~wr_q;
    assign bus_wr  = wr_rise & ~cs_r & a_d_r;
    assign addr_wr = wr_rise & ~cs_r & ~a_d_r;
    assign rd_fall = ~rd_r & rd_q & ~cs_r & a_d_r;

    assign dato = oe ? rdata : 8'hzz;

    // BCD year divisible by 4 <=> (2*tens + units) divisible by 4
    always_comb begin
        lsum = {2'b00, year[4], 1'b0} + year[3:0];
        leap = (lsum[1:0] == 2'b00);
        case (mon)
            8'h01, 8'h03, 8'h05, 8'h07, 8'h08, 8'h10, 8'h12: mlen = 8'h31;
            8'h04, 8'h06, 8'h09, 8'h11:                      mlen = 8'h30;
            8'h02:   mlen = leap ? 8'h29 : 8'h28;
            default: mlen = 8'h31;
        endcase
    end

    // Tick ripple first, then a bus write overrides only the register it targets.
    always_comb begin
        sec_n  = sec;
        mins_n = mins;
        hour_n = hour;
        day_n  = day;
        mon_n  = mon;
        year_n = year;
        wday_n = wday;
        if (tick) begin
            if (sec >= 8'h59) begin
                sec_n = 8'h00;
                if (mins >= 8'h59) begin
                    mins_n = 8'h00;
                    if (hour >= 8'h23) begin
                        hour_n = 8'h00;
                        if (day >= mlen) begin
                            day_n  = 8'h01;
                            wday_n = (wday >= 8'h07) ? 8'h01 : bcd_inc(wday);
                            if (mon >= 8'h12) begin
                                mon_n  = 8'h01;
                                year_n = (year >= 8'h99) ? 8'h00 : bcd_inc(year);
                            end else begin
                                mon_n = bcd_inc(mon);
                            end
                        end else begin
                            day_n = bcd_inc(day);
                        end
                    end else begin
                        hour_n = bcd_inc(hour);
                    end
                end else begin
                    mins_n = bcd_inc(mins);
                end
            end else begin
                sec_n = bcd_inc(sec);
            end
        end
`ifdef RTC_TIMER_EN
        t_sec_n  = t_sec;
        t_min_n  = t_min;
        t_hour_n = t_hour;
        t_run_n  = t_run;
        t_done_n = t_done;
        if (tick && t_run) begin
            if (t_sec == 8'h00 && t_min == 8'h00 && t_hour == 8'h00) begin
                t_run_n  = 1'b0;
                t_done_n = 1'b1;
            end else begin
                t_sec_n = bcd_dec(t_sec, 8'h59);
                if (t_sec == 8'h00) begin
                    t_min_n = bcd_dec(t_min, 8'h59);
                    if (t_min == 8'h00) t_hour_n = bcd_dec(t_hour, 8'h23);
                end
                if (t_sec_n == 8'h00 && t_min_n == 8'h00 && t_hour_n == 8'h00) begin
                    t_run_n  = 1'b0;
                    t_done_n = 1'b1;
                end
            end
        end
`endif
        if (bus_wr) begin
            case (addr)
                8'h21: sec_n  = dato_r;
                8'h22: mins_n = dato_r;
                8'h23: hour_n = dato_r;
                8'h24: day_n  = dato_r;
                8'h25: mon_n  = dato_r;
                8'h26: year_n = dato_r;
                8'h27: wday_n = dato_r;
`ifdef RTC_TIMER_EN
                8'h40: begin
                    t_run_n  = dato_r[0];
                    t_done_n = dato_r[1];
                end
                8'h41: t_sec_n  = dato_r;
                8'h42: t_min_n  = dato_r;
                8'h43: t_hour_n = dato_r;
`endif
                default: ;
            endcase
        end
    end

    always_comb begin
        case (addr)
            8'h21:   rd_val = sec;
            8'h22:   rd_val = mins;
            8'h23:   rd_val = hour;
            8'h24:   rd_val = day;
            8'h25:   rd_val = mon;
            8'h26:   rd_val = year;
            8'h27:   rd_val = wday;
`ifdef RTC_TIMER_EN
            8'h40:   rd_val = {6'b0, t_done, t_run};
            8'h41:   rd_val = t_sec;
            8'h42:   rd_val = t_min;
            8'h43:   rd_val = t_hour;
`endif
            default: rd_val = 8'h00;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cs_r     <= 1'b1;
            rd_r     <= 1'b1;
            wr_r     <= 1'b1;
            a_d_r    <= 1'b0;
            rd_q     <= 1'b1;
            wr_q     <= 1'b1;
            dato_r   <= 8'h00;
            addr     <= 8'h00;
            rdata    <= 8'h00;
            oe       <= 1'b0;
            tick_cnt <= '0;
            sec      <= 8'h00;
            mins     <= 8'h00;
            hour     <= 8'h00;
            day      <= 8'h01;
            mon      <= 8'h01;
            year     <= 8'h00;
            wday     <= 8'h01;
`ifdef RTC_TIMER_EN
            t_sec    <= 8'h00;
            t_min    <= 8'h00;
            t_hour   <= 8'h00;
            t_run    <= 1'b0;
            t_done   <= 1'b0;
`endif
        end else begin
            cs_r     <= cs;
            rd_r     <= rd;
            wr_r     <= wr;
            a_d_r    <= a_d;
            dato_r   <= dato;
            rd_q     <= rd_r;
            wr_q     <= wr_r;
            tick_cnt <= tick ? '0 : tick_cnt + 1'b1;
            if (addr_wr) addr <= dato_r;
            if (rd_fall) rdata <= rd_val;
            // never drive while a write strobe is also low
            oe       <= ~rd_r & ~cs_r & a_d_r & wr_r;
            sec      <= sec_n;
            mins     <= mins_n;
            hour     <= hour_n;
            day      <= day_n;
            mon      <= mon_n;
            year     <= year_n;
            wday     <= wday_n;
`ifdef RTC_TIMER_EN
            t_sec    <= t_sec_n;
            t_min    <= t_min_n;
            t_hour   <= t_hour_n;
            t_run    <= t_run_n;
            t_done   <= t_done_n;
`endif
        end
    end

`ifdef RTC_TIMER_EN
    assign timer_done = t_done;
`else
    assign timer_done = 1'b0;
`endif
endmodule

// File: doc/rtc_bus_responder.md
# rtc_bus_responder

Synthesizable responder for the RTC multiplexed address/data bus (`cs`, `rd`, `wr`, `a_d`, `dato`) driven by the RTC controller. It holds a BCD time/date register file that advances once per second, plus an optional countdown timer, and answers address, write and read cycles exactly as the external RTC chip does. It sits on the far side of the bus in board-less simulation and in loop-back FPGA builds, replacing the physical RTC.

## Interface
- `TICK_DIV`, default 100_000_000: `clk` cycles per one-second tick; must be ≥ 2.
- `clk` in 1: system clock; all bus strobes are synchronous to it.
- `reset` in 1: synchronous, active-high.
- `cs` in 1: chip select, active low.
- `rd` in 1: read strobe, active low.
- `wr` in 1: write strobe, active low.
- `a_d` in 1: 0 = address phase, 1 = data phase.
- `dato` inout 8: multiplexed bus; driven only during read data phase, otherwise high-Z.
- `timer_done` out 1: high while the timer-done flag (0x40 bit1) is set.

## Operation
- Register map (BCD), reset values in brackets:
  - 0x21 seconds [00], 0x22 minutes [00], 0x23 hours, 24 h [00]
  - 0x24 day [01], 0x25 month [01], 0x26 year [00], 0x27 weekday [01]
  - 0x41 timer sec [00], 0x42 timer min [00], 0x43 timer hour [00]
  - 0x40 timer control [00]: bit0 run, bit1 done; other bits read 0.
- Unmapped addresses: read 0x00, writes ignored. Address latch resets to 0x00.
- Bus strobes pass through one register stage each; edges are detected on the registered copies.
- Address cycle: `cs`=0, `a_d`=0, rising edge of `wr` → address latch ← `dato`.
- Write cycle: `cs`=0, `a_d`=1, rising edge of `wr` → reg[address] ← `dato`. Values are stored unvalidated.
- Read cycle: `cs`=0, `a_d`=1, falling edge of `rd` → snapshot reg[address] into the output register. Drive `dato` while registered `rd`=0 and `cs`=0, and `a_d`=1.
- `rd` and `wr` low together: the write is honoured, `dato` is not driven.
- Tick counter runs 0..TICK_DIV-1. At the terminal count it issues a one-cycle `tick`.
- Time advance on `tick`, ripple in one cycle:
  - seconds 59→00 carries into minutes; minutes 59→00 carries into hours; hours 23→00 carries into day.
  - Day wraps to 01 past the month length: 31 for months 01/03/05/07/08/10/12, 30 for 04/06/09/11, and 29 for 02 when the BCD year is divisible by 4, else 28. The day wrap carries into month and also advances weekday.
  - Month 12→01 carries into year; year 99→00.
  - Weekday 07→01.
- BCD increment: if the low nibble ≥ 9, the low nibble becomes 0 and the high nibble increments. The wrap test is value ≥ limit, so invalid contents wrap instead of running away.
- A bus write in the same cycle as `tick` targeting a register the tick would change: the write wins for that register; carries into higher registers still apply.

## Timing
- Strobe low/high widths ≥ 2 `clk`.
- Write commits 2 cycles after raw `wr` rises.
- `dato` is valid 2 cycles after raw `rd` falls and released (Z) 1 cycle after registered `rd` rises.
- `reset` mid-cycle: all registers return to reset values, `dato` goes Z the same edge, and the tick counter returns to 0.
- First tick occurs TICK_DIV cycles after reset deassertion.

## Configuration
- `RTC_TIMER_EN` defined:
  - Countdown timer present. When run=1, on each `tick` the timer decrements in BCD (borrow sec→min→hour, 00→59).
  - When it reaches 00:00:00, run clears and done sets in the same cycle. `timer_done` follows done.
  - Writing 0x40 sets run/done directly; writing 0 to bit1 clears done.
  - Writing run=1 while the timer is 00:00:00 sets done on the next tick.
- Not defined: 0x40–0x43 behave as unmapped (read 0x00, writes ignored), and `timer_done` is tied to 0.

## Test plan
- Reset, then address 0x21 and read → `dato`=0x00. Read 0x24 → 0x01. `timer_done`=0, `dato` Z outside reads.
- Write 0x59/0x59/0x23 to 0x21/0x22/0x23, 0x31 to 0x24, 0x12 to 0x25, 0x99 to 0x26, 0x07 to 0x27; one tick → reads 00,00,00,01,01,00,01.
- Set day 0x28, month 0x02, year 0x23, time 23:59:59; tick → day 01, month 03. Repeat with year 0x24 → day 29, month 02.
- Write 0x45 to 0x21 in the exact cycle of `tick` → seconds reads 0x45, not 0x46.
- With `RTC_TIMER_EN`, write timer 00:01:00 and 0x40←0x01; after 60 ticks → timer 00:00:00, 0x40 reads 0x02, `timer_done`=1. Write 0x00 to 0x40 → `timer_done`=0.
- Without `RTC_TIMER_EN`: write 0x55 to 0x41, read back → 0x00, and `timer_done` stays 0.
